fft_frame_reader: RTL and testbench

FFT_FRAME_READER -- requirements
Module: fft_frame_reader

---
 rtl/fft_frame_reader.sv | 129 ++++++++++++
 tb/tb_fft_frame_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_reader.sv
// Ping-pong frame reader: drains a filled RAM buffer into the FFT core one sample at a time,
// while steering the write controller to the other buffer.
//
// state   | meaning
// IDLE    | waiting for ram_full from the write controller
// FETCH   | read enable on the buffer being drained
// LOAD    | capture RAM dout into fft_data
// PRESENT | fft_valid high, holding fft_data until fft_ready
module fft_frame_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ram_full,
  output logic              sel_ram,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en_ram_0,
  output logic              rd_en_ram_1,
  input  logic [DATA_W-1:0] ram_0_dout,
  input  logic [DATA_W-1:0] ram_1_dout,
  output logic [DATA_W-1:0] fft_data,
  output logic              fft_valid,
  output logic              fft_last,
  input  logic              fft_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_LOAD    = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic              sel_ram_q, sel_ram_d;
  logic              rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] fft_data_q, fft_data_d;
  logic              overrun_q, overrun_d;
  logic              at_last;
  logic              start;
  logic              drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_ram_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_addr_q  <= '0;
      fft_data_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_ram_q  <= sel_ram_d;
      rd_sel_q   <= rd_sel_d;
      rd_addr_q  <= rd_addr_d;
      fft_data_q <= fft_data_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_ram_d  = sel_ram_q;
    rd_sel_d   = rd_sel_q;
    rd_addr_d  = rd_addr_q;
    fft_data_d = fft_data_q;
    overrun_d  = overrun_q;
    at_last    = (rd_addr_q == LAST_ADDR);
    start      = 1'b0;
    drop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        start = ram_full;
      end
      S_FETCH: begin
        state_d = S_LOAD;
        drop    = ram_full;
      end
      S_LOAD: begin
        fft_data_d = rd_sel_q ? ram_1_dout : ram_0_dout;
        state_d    = S_PRESENT;
        drop       = ram_full;
      end
      S_PRESENT: begin
        // A new frame landing exactly on the final handshake chains straight into it.
        drop = ram_full && !(fft_ready && at_last);
        if (fft_ready) begin
          if (at_last) begin
            start   = ram_full;
            state_d = S_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      rd_sel_d  = sel_ram_q;
      sel_ram_d = ~sel_ram_q;
      rd_addr_d = '0;
      state_d   = S_FETCH;
    end

    if (clr_overrun) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  assign sel_ram     = sel_ram_q;
  assign rd_addr     = rd_addr_q;
  assign rd_en_ram_0 = (state_q == S_FETCH) && !rd_sel_q;
  assign rd_en_ram_1 = (state_q == S_FETCH) && rd_sel_q;
  assign fft_data    = fft_data_q;
  assign fft_valid   = (state_q == S_PRESENT);
  assign fft_last    = fft_valid && at_last;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_frame_reader.sv
// Directed bench for fft_frame_reader (ADDR_W=3): expected samples are queued when a frame
// is started and a negedge monitor pops and compares them on every handshake.
module tb_fft_frame_reader;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              ram_full = 1'b0;
  logic              fft_ready = 1'b0;
  logic              clr_overrun = 1'b0;
  logic              sel_ram;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en_ram_0, rd_en_ram_1;
  logic [DATA_W-1:0] ram_0_dout = '0, ram_1_dout = '0;
  logic [DATA_W-1:0] fft_data;
  logic              fft_valid, fft_last, busy, overrun;

  logic [DATA_W-1:0] mem0 [8];
  logic [DATA_W-1:0] mem1 [8];
  logic [DATA_W:0]   exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  fft_frame_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .ram_full(ram_full), .sel_ram(sel_ram),
    .rd_addr(rd_addr), .rd_en_ram_0(rd_en_ram_0), .rd_en_ram_1(rd_en_ram_1),
    .ram_0_dout(ram_0_dout), .ram_1_dout(ram_1_dout), .fft_data(fft_data),
    .fft_valid(fft_valid), .fft_last(fft_last), .fft_ready(fft_ready),
    .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always @(posedge clock) begin
    if (rd_en_ram_0) ram_0_dout <= mem0[rd_addr];
    if (rd_en_ram_1) ram_1_dout <= mem1[rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push_frame(input bit which);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 7), (which ? mem1[i] : mem0[i])});
  endtask

  task automatic start_frame(input bit which);
    ram_full = 1'b1;
    push_frame(which);
    cyc = 0;
    step();
    ram_full = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    chk(name, busy, 0);
  endtask

  always @(negedge clock) begin : monitor
    logic [DATA_W:0] e;
    if (reset_n && fft_valid && fft_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_sample: got 0x%0h, no sample expected", fft_data);
      end else begin
        e = exp_q.pop_front();
        chk("fft_data", fft_data, e[DATA_W-1:0]);
        chk("fft_last", fft_last, e[DATA_W]);
      end
    end
    if (reset_n && (rd_en_ram_0 || rd_en_ram_1))
      chk("rd_en_other_buffer", {rd_en_ram_1, rd_en_ram_0}, sel_ram ? 2'b01 : 2'b10);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem0[i] = 16'h10 + 16'(i);
      mem1[i] = 16'h20 + 16'(i);
    end
    #1 reset_n = 1'b0;
    #1;
    chk("rst_sel_ram", sel_ram, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", fft_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_fft_data", fft_data, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    fft_ready = 1'b1;
    step();
    step();

    // single frame from RAM0
    start_frame(0);
    while (cyc <= 25) begin
      chk("t1_rd_en_ram_0", rd_en_ram_0, (cyc % 3 == 1) && (cyc <= 22));
      chk("t1_rd_en_ram_1", rd_en_ram_1, 0);
      chk("t1_valid", fft_valid, (cyc % 3 == 0) && (cyc >= 3) && (cyc <= 24));
      chk("t1_busy", busy, cyc <= 24);
      chk("t1_sel_ram", sel_ram, 1);
      step();
    end

    // ping-pong: second frame comes from RAM1
    start_frame(1);
    chk("t2_sel_ram", sel_ram, 0);
    chk("t2_rd_en_ram_1", rd_en_ram_1, 1);
    chk("t2_rd_en_ram_0", rd_en_ram_0, 0);
    wait_idle("t2_idle", 40);
    chk("t2_idle_cycle", cyc, 25);

    // backpressure on sample 2
    start_frame(0);
    while (cyc < 9) step();
    fft_ready = 1'b0;
    repeat (5) begin
      chk("t3_hold_valid", fft_valid, 1);
      chk("t3_hold_data", fft_data, 16'h12);
      chk("t3_hold_addr", rd_addr, 2);
      chk("t3_hold_no_rd", {rd_en_ram_1, rd_en_ram_0}, 0);
      step();
    end
    fft_ready = 1'b1;
    chk("t3_release_data", fft_data, 16'h12);
    step();
    chk("t3_resume_rd_en", rd_en_ram_0, 1);
    chk("t3_resume_addr", rd_addr, 3);
    wait_idle("t3_idle", 40);
    chk("t3_idle_cycle", cyc, 30);

    // overrun during sample 4, then clear coinciding with another drop
    start_frame(1);
    chk("t4_sel_ram_start", sel_ram, 0);
    while (cyc < 15) step();
    chk("t4_present_addr", rd_addr, 4);
    ram_full = 1'b1;
    step();
    ram_full = 1'b0;
    chk("t4_overrun_set", overrun, 1);
    chk("t4_sel_unchanged", sel_ram, 0);
    chk("t4_next_fetch", rd_en_ram_1, 1);
    chk("t4_next_addr", rd_addr, 5);
    step();
    ram_full = 1'b1;
    clr_overrun = 1'b1;
    step();
    ram_full = 1'b0;
    clr_overrun = 1'b0;
    chk("t4_clr_vs_event", overrun, 1);
    chk("t4_sel_still", sel_ram, 0);
    wait_idle("t4_idle", 40);
    chk("t4_idle_cycle", cyc, 25);
    chk("t4_sticky", overrun, 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("t4_cleared", overrun, 0);

    // back-to-back: ram_full on the last handshake
    start_frame(0);
    while (cyc < 24) step();
    chk("t5_last", fft_last, 1);
    ram_full = 1'b1;
    push_frame(1);
    step();
    ram_full = 1'b0;
    chk("t5_no_overrun", overrun, 0);
    chk("t5_rd_en_ram_1", rd_en_ram_1, 1);
    chk("t5_rd_en_ram_0", rd_en_ram_0, 0);
    chk("t5_sel_ram", sel_ram, 0);
    chk("t5_addr", rd_addr, 0);
    wait_idle("t5_idle", 60);
    chk("t5_idle_cycle", cyc, 49);
    chk("t5_overrun_end", overrun, 0);

    // reset mid-frame at sample 5
    start_frame(0);
    while (cyc < 9) step();
    ram_full = 1'b1;
    step();
    ram_full = 1'b0;
    chk("t6_overrun_pre", overrun, 1);
    while (cyc < 18) step();
    chk("t6_pre_data", fft_data, 16'h15);
    chk("t6_pre_valid", fft_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_sel", sel_ram, 0);
    chk("t6_rst_addr", rd_addr, 0);
    chk("t6_rst_rd_en", {rd_en_ram_1, rd_en_ram_0}, 0);
    chk("t6_rst_data", fft_data, 0);
    chk("t6_rst_valid", fft_valid, 0);
    chk("t6_rst_last", fft_last, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_abandoned", exp_q.size(), 3);
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("t6_wait_busy", busy, 0);
    chk("t6_wait_rd_en", {rd_en_ram_1, rd_en_ram_0}, 0);
    start_frame(0);
    chk("t6_restart_rd_en", rd_en_ram_0, 1);
    chk("t6_restart_addr", rd_addr, 0);
    chk("t6_restart_sel", sel_ram, 1);
    wait_idle("t6_idle", 40);
    chk("t6_idle_cycle", cyc, 25);
    step();
    chk("end_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
